// File: rtl/ppe_row_conv.sv
// ppe_row_conv: row-convolution processing element for the SNN mesh.
//   Weight packets load a FILTER_W-tap filter. Each spike packet latches a binary
//   input row and then emits OFMAP_W partial sums, one per output handshake.
//   Optional build macro PPE_ADDR_FILTER_EN: drop packets whose addr != PE_ADDR.
// Ports:
//   clk_i, reset_i                       clock, asynchronous active-high reset
//   in_valid_i/in_ready_o/in_pkt_i       ingress {addr, opcode(0 wt,1 spike), data}
//   out_valid_o/out_ready_i              psum handshake
//   out_psum_o, out_idx_o, out_last_o    partial sum, position j, j==OFMAP_W-1
//   err_nowt_o                           sticky: spike seen before filter complete
module ppe_row_conv #(
   parameter int ADDR_W   = 4,
   parameter int PE_ADDR  = 5,
   parameter int WEIGHT_W = 8,
   parameter int FILTER_W = 5,
   parameter int IFMAP_W  = 25,
   localparam int PKT_W   = ADDR_W + 1 + IFMAP_W,
   localparam int WPP     = IFMAP_W / WEIGHT_W,
   localparam int WPKTS   = (FILTER_W + WPP - 1) / WPP,
   localparam int OFMAP_W = IFMAP_W - FILTER_W + 1,
   localparam int PSUM_W  = WEIGHT_W + $clog2(FILTER_W + 1),
   localparam int IDX_W   = $clog2(OFMAP_W)
) (
   input  logic              clk_i,
   input  logic              reset_i,
   input  logic              in_valid_i,
   output logic              in_ready_o,
   input  logic [PKT_W-1:0]  in_pkt_i,
   output logic              out_valid_o,
   input  logic              out_ready_i,
   output logic [PSUM_W-1:0] out_psum_o,
   output logic [IDX_W-1:0]  out_idx_o,
   output logic              out_last_o,
   output logic              err_nowt_o
);
   localparam int CW = $clog2(WPKTS + 1);
   typedef enum logic [1:0] {WLOAD, READY, COMPUTE} state_t;
   state_t              state_q, state_d;
   logic [CW-1:0]       wcnt_q, wcnt_d, base;
   logic [IDX_W-1:0]    idx_q, idx_d;
   logic [WEIGHT_W-1:0] w_q [FILTER_W];
   logic [WEIGHT_W-1:0] w_d [FILTER_W];
   logic [IFMAP_W-1:0]  row_q, row_d;
   logic [PSUM_W-1:0]   psum [OFMAP_W];
   logic                err_q, err_d, rdy_q, hit, acc, wr, last, spk;
`ifdef PPE_ADDR_FILTER_EN
   assign hit = in_pkt_i[PKT_W-1:IFMAP_W+1] == ADDR_W'(PE_ADDR);
`else
   logic unused_addr;
   assign unused_addr = ^in_pkt_i[PKT_W-1:IFMAP_W+1];
   assign hit = 1'b1;
`endif
   assign spk  = in_pkt_i[IFMAP_W];
   assign acc  = in_valid_i & rdy_q & hit;
   assign last = (state_q == COMPUTE) && (idx_q == IDX_W'(OFMAP_W - 1));
   always_comb begin
      state_d = state_q;
      wcnt_d  = wcnt_q;
      idx_d   = idx_q;
      row_d   = row_q;
      err_d   = err_q;
      wr      = 1'b0;
      case (state_q)
         WLOAD: begin
            err_d = err_q | (acc & spk);
            wr    = acc & ~spk;
         end
         READY: begin
            wr = acc & ~spk;
            if (acc & spk) begin
               row_d   = in_pkt_i[IFMAP_W-1:0];
               idx_d   = '0;
               state_d = COMPUTE;
            end
         end
         COMPUTE: if (out_ready_i) begin
            idx_d   = last ? '0 : idx_q + IDX_W'(1);
            state_d = last ? READY : COMPUTE;
         end
         default: state_d = WLOAD;
      endcase
      // a weight packet arriving with a complete filter restarts loading at slot 0
      base = (state_q == READY) ? '0 : wcnt_q;
      if (wr) begin
         wcnt_d  = (base == CW'(WPKTS - 1)) ? '0 : base + CW'(1);
         state_d = (base == CW'(WPKTS - 1)) ? READY : WLOAD;
      end
      for (int k = 0; k < FILTER_W; k++)
         w_d[k] = (wr && base == CW'(k / WPP)) ? in_pkt_i[WEIGHT_W*(k%WPP) +: WEIGHT_W] : w_q[k];
   end
   always_comb begin
      for (int j = 0; j < OFMAP_W; j++) begin
         psum[j] = '0;
         for (int k = 0; k < FILTER_W; k++)
            psum[j] = psum[j] + (row_q[j+k] ? PSUM_W'(w_q[k]) : '0);
      end
   end
   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         state_q <= WLOAD;
         wcnt_q  <= '0;
         idx_q   <= '0;
         row_q   <= '0;
         err_q   <= 1'b0;
         rdy_q   <= 1'b0;
         for (int k = 0; k < FILTER_W; k++) w_q[k] <= '0;
      end else begin
         state_q <= state_d;
         wcnt_q  <= wcnt_d;
         idx_q   <= idx_d;
         row_q   <= row_d;
         err_q   <= err_d;
         rdy_q   <= state_d != COMPUTE;
         for (int k = 0; k < FILTER_W; k++) w_q[k] <= w_d[k];
      end
   end
   assign in_ready_o  = rdy_q;
   assign out_valid_o = state_q == COMPUTE;
   assign out_psum_o  = out_valid_o ? psum[idx_q] : '0;
   assign out_idx_o   = idx_q;
   assign out_last_o  = last;
   assign err_nowt_o  = err_q;
endmodule

// File: tb/tb_ppe_row_conv.sv
// tb_ppe_row_conv: randomized bench for ppe_row_conv against an arithmetic reference model.
module tb_ppe_row_conv;
   localparam int ADDR_W = 4, PE_ADDR = 5, WEIGHT_W = 8, FILTER_W = 5, IFMAP_W = 25;
   localparam int PKT_W   = ADDR_W + 1 + IFMAP_W;
   localparam int WPP     = IFMAP_W / WEIGHT_W;
   localparam int WPKTS   = (FILTER_W + WPP - 1) / WPP;
   localparam int OFMAP_W = IFMAP_W - FILTER_W + 1;
   localparam int PSUM_W  = WEIGHT_W + $clog2(FILTER_W + 1);
   localparam int IDX_W   = $clog2(OFMAP_W);
   logic              clk = 1'b0, reset = 1'b1, in_valid = 1'b0, out_ready = 1'b1;
   logic              in_ready, out_valid, out_last, err_nowt;
   logic [PKT_W-1:0]  in_pkt = '0;
   logic [PSUM_W-1:0] out_psum;
   logic [IDX_W-1:0]  out_idx;
   int                checks = 0, errors = 0;
   int                wm [FILTER_W];
   bit                fv = 1'b0, errm = 1'b0;
   int                wc = 0;
   always #5 clk = ~clk;
   ppe_row_conv #(.ADDR_W(ADDR_W), .PE_ADDR(PE_ADDR), .WEIGHT_W(WEIGHT_W),
                  .FILTER_W(FILTER_W), .IFMAP_W(IFMAP_W)) dut (
      .clk_i(clk), .reset_i(reset), .in_valid_i(in_valid), .in_ready_o(in_ready),
      .in_pkt_i(in_pkt), .out_valid_o(out_valid), .out_ready_i(out_ready),
      .out_psum_o(out_psum), .out_idx_o(out_idx), .out_last_o(out_last),
      .err_nowt_o(err_nowt));
   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0d exp %0d at %0t", tag, got, exp, $time);
      end
   endtask
   task automatic model_reset();
      for (int k = 0; k < FILTER_W; k++) wm[k] = 0;
      fv = 1'b0; wc = 0; errm = 1'b0;
   endtask
   task automatic collect(input logic [IFMAP_W-1:0] row, input bit rnd, input int stop_at);
      int ex [OFMAP_W];
      int j = 0, cyc = 0;
      for (int p = 0; p < OFMAP_W; p++) begin
         ex[p] = 0;
         for (int k = 0; k < FILTER_W; k++) if (row[p+k]) ex[p] += wm[k];
      end
      while (j < OFMAP_W && cyc < 400) begin
         @(negedge clk);
         cyc++;
         if (j == stop_at) break;
         chk("out_valid", out_valid, 1);
         chk("out_idx", out_idx, j);
         chk("out_psum", out_psum, ex[j]);
         chk("out_last", out_last, j == OFMAP_W - 1);
         chk("busy_in_ready", in_ready, 0);
         out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
         if (out_ready) j++;
      end
      if (stop_at < 0) begin
         chk("psums_delivered", j, OFMAP_W);
         @(negedge clk);
         chk("done_out_valid", out_valid, 0);
         chk("done_in_ready", in_ready, 1);
         out_ready = 1'b1;
      end
   endtask
   task automatic send(input int addr, input bit op, input logic [IFMAP_W-1:0] data,
                       input bit rnd, input int stop_at);
      int n = 0;
      bit take = 1'b1;
      @(negedge clk);
      in_pkt   = {addr[ADDR_W-1:0], op, data};
      in_valid = 1'b1;
      while (!in_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      chk("accept", in_ready, 1);
      @(posedge clk);
      #1 in_valid = 1'b0;
`ifdef PPE_ADDR_FILTER_EN
      take = (addr == PE_ADDR);
`endif
      if (take && !op) begin
         if (fv) begin
            fv = 1'b0;
            wc = 0;
         end
         for (int s = 0; s < WPP; s++)
            if (wc * WPP + s < FILTER_W) wm[wc*WPP+s] = int'(data[WEIGHT_W*s +: WEIGHT_W]);
         wc++;
         if (wc == WPKTS) begin
            wc = 0;
            fv = 1'b1;
         end
      end else if (take && op && !fv) errm = 1'b1;
      chk("err_nowt", err_nowt, errm);
      if (take && op && fv) collect(data, rnd, stop_at);
      else chk("no_out_valid", out_valid, 0);
   endtask
   initial begin
      model_reset();
      repeat (3) @(negedge clk);
      chk("rst_in_ready", in_ready, 0);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_out_psum", out_psum, 0);
      chk("rst_out_idx", out_idx, 0);
      chk("rst_out_last", out_last, 0);
      chk("rst_err", err_nowt, 0);
      reset = 1'b0;
      @(posedge clk);
      #1 chk("post_rst_in_ready", in_ready, 1);
      send(PE_ADDR, 1'b1, 25'h1FFFFFF, 1'b0, -1);
      send(PE_ADDR, 1'b0, 25'h0030201, 1'b0, -1);
      send(PE_ADDR, 1'b0, 25'h0060504, 1'b0, -1);
      send(PE_ADDR, 1'b1, 25'h0AAAAAA, 1'b0, -1);
      send(PE_ADDR, 1'b1, 25'h1555555, 1'b0, -1);
      send(PE_ADDR, 1'b1, 25'h1FFFFFF, 1'b0, -1);
      send(PE_ADDR, 1'b1, IFMAP_W'($urandom), 1'b1, -1);
      send(3, 1'b0, 25'h0090807, 1'b0, -1);
      send(PE_ADDR, 1'b1, 25'h0AAAAAA, 1'b0, -1);
      send(PE_ADDR, 1'b0, 25'h0060504, 1'b0, -1);
      send(PE_ADDR, 1'b1, 25'h1555555, 1'b1, -1);
      for (int i = 0; i < 60; i++)
         send(($urandom_range(0, 7) == 0) ? 3 : PE_ADDR, 1'($urandom_range(0, 2) != 0),
              IFMAP_W'($urandom), 1'b1, -1);
      send(PE_ADDR, 1'b0, IFMAP_W'($urandom), 1'b0, -1);
      send(PE_ADDR, 1'b0, IFMAP_W'($urandom), 1'b0, -1);
      if (!fv) send(PE_ADDR, 1'b0, IFMAP_W'($urandom), 1'b0, -1);
      send(PE_ADDR, 1'b1, 25'h1FFFFFF, 1'b0, 7);
      reset = 1'b1;
      #1;
      model_reset();
      chk("midrst_out_valid", out_valid, 0);
      chk("midrst_out_psum", out_psum, 0);
      chk("midrst_out_idx", out_idx, 0);
      chk("midrst_out_last", out_last, 0);
      chk("midrst_in_ready", in_ready, 0);
      chk("midrst_err", err_nowt, 0);
      @(negedge clk);
      reset = 1'b0;
      @(posedge clk);
      #1 chk("midrst_ready_after", in_ready, 1);
      send(PE_ADDR, 1'b1, 25'h0AAAAAA, 1'b0, -1);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/ppe_row_conv.md
# ppe_row_conv

Clocked, parametrised row-convolution processing element for the SNN accelerator mesh. It consumes address/opcode packets from the NoC ingress over a valid/ready channel. Weight packets load a FILTER_W-tap filter row. Each spike packet carries an IFMAP_W-bit binary input row and produces OFMAP_W partial sums, one per output handshake, toward the accumulator stage. It generalises the fixed 5-tap/25-spike PPE: filter width, row length, weight width, address width and node address are all parameters, and it adds address filtering, a reload path and error reporting.

## Interface
- ADDR_W, 4, packet address field width
- PE_ADDR, 5, this node's address
- WEIGHT_W, 8, unsigned weight width
- FILTER_W, 5, filter taps
- IFMAP_W, 25, spikes per input row; also the packet data-field width
- Derived, not overridable:
  - PKT_W = ADDR_W+1+IFMAP_W
  - WPP = IFMAP_W/WEIGHT_W (floor, must be ≥1)
  - WPKTS = ceil(FILTER_W/WPP)
  - OFMAP_W = IFMAP_W-FILTER_W+1
  - PSUM_W = WEIGHT_W+$clog2(FILTER_W+1)
  - IDX_W = $clog2(OFMAP_W)
- clk  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-high
- in_valid  in  1  packet valid
- in_ready  out  1  packet accepted when in_valid&in_ready at clk edge
- in_pkt  in  PKT_W  [PKT_W-1:IFMAP_W+1] addr, [IFMAP_W] opcode (0 weight, 1 spike), [IFMAP_W-1:0] data
- out_valid  out  1  psum valid
- out_ready  in  1  downstream accepts
- out_psum  out  PSUM_W  partial sum
- out_idx  out  IDX_W  output position j
- out_last  out  1  high with j = OFMAP_W-1
- err_nowt  out  1  sticky: spike packet arrived before the filter was complete

## Operation
- Weight packet: slot s is data[WEIGHT_W*s+WEIGHT_W-1 : WEIGHT_W*s] and writes w[wcnt*WPP+s]. Slots beyond FILTER_W-1 and leftover data bits are discarded. wcnt increments per weight packet; the filter becomes valid when wcnt reaches WPKTS, and wcnt then returns to 0.
- Spike packet: data[i] is spike i. The row is latched and the block computes psum[j] = Σ_{k<FILTER_W} (in[j+k] ? w[k] : 0) for j = 0..OFMAP_W-1. This is a parallel conditional-add tree over registered state. Unsigned, full precision, no overflow possible.
- States:
  - WLOAD (reset state): in_ready=1.
    - Weight packet: store it; on the final packet go to READY.
    - Spike packet: consume, drop, set err_nowt, stay.
  - READY: in_ready=1.
    - Spike packet: latch the row, idx←0, go to COMPUTE.
    - Weight packet: clear filter-valid, restart loading at w[0..WPP-1], wcnt←1, go to WLOAD. If WPKTS=1, stay in READY with the new weights.
  - COMPUTE: in_ready=0, out_valid=1.
    - On out handshake: idx++.
    - On handshake with idx = OFMAP_W-1: go to READY.
- Outputs are derived from registers only. out_psum, out_idx and out_last hold stable while out_valid & !out_ready.
- Reset (any state, including mid-COMPUTE): state←WLOAD, wcnt←0, idx←0, weights and row←0, err_nowt←0. The in-flight row is abandoned and no further psums are emitted.
- Reset values: in_ready=0 while reset is asserted and 1 in the first cycle after deassertion; out_valid, out_psum, out_idx, out_last and err_nowt are all 0.

## Timing
- Input accepted at edge t → out_valid high for cycle t+1, carrying j=0.
- With out_ready held at 1: psums j = 0..OFMAP_W-1 appear in cycles t+1..t+OFMAP_W.
- in_ready rises in cycle t+OFMAP_W+1. Sustained rate is one row per OFMAP_W+1 cycles.
- Back-pressure: each cycle with out_ready=0 extends COMPUTE by one cycle. out_valid never drops before its handshake.
- Weight packets are accepted one per cycle. The filter is usable the cycle after the last weight packet is accepted.

## Configuration
- PPE_ADDR_FILTER_EN defined: packets with addr ≠ PE_ADDR are accepted in WLOAD/READY and discarded with no state change. They never set err_nowt.
- PPE_ADDR_FILTER_EN undefined: the address field is ignored and every packet is processed.

## Test plan
- Weights {3,2,1} then {6,5,4} at PE_ADDR 5, then spike row data[i]=i%2 with out_ready=1 → w = 1,2,3,4,5. Expect 21 psums alternating 6,9,6,…,6: j even →6, j odd →9. out_last with j=20, psum 6. Outputs in cycles t+1..t+21.
- Second row data[i]=(i+1)%2 → psums alternate 9,6,…,9. in_ready is low for exactly 21 cycles.
- Spike packet sent before any weights → consumed, err_nowt=1, no out_valid. After loading weights and sending an all-ones row, every psum = 15.
- out_ready toggled 1,0,0,1 during COMPUTE → out_psum and out_idx hold during the stall cycles. The full 21-entry sequence is delivered in order with no loss or duplication.
- Reset asserted with idx=7 mid-COMPUTE → outputs are 0 immediately. After release: state WLOAD, in_ready=1, and a spike packet sets err_nowt.
- With PPE_ADDR_FILTER_EN, a weight packet at addr 3 → no effect, and the subsequent row produces the same psums as before. Without the macro, the same packet overwrites w0..w2.
